// File: rtl/median3x3_filter.sv
`timescale 1ns/1ps
// median3x3_filter
// Three-stage pipelined 3x3 median filter. Each accepted window is reduced
// with the row-sort network: sort each row, then take max-of-mins,
// med-of-meds and min-of-maxes, and the median of those three values is the
// median of all nine pixels. A per-window bypass flag selects the centre
// pixel instead. The block counts emitted pixels and raises a sticky done
// when a full frame has been produced.
module median3x3_filter #(
    parameter int DATA_W     = 8,
    parameter int NUM_PIXELS = 65536,
    parameter int CNT_W      = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              bypass,
    input  logic [DATA_W-1:0] pixelr1,
    input  logic [DATA_W-1:0] pixelr2,
    input  logic [DATA_W-1:0] pixelr3,
    input  logic [DATA_W-1:0] pixelr4,
    input  logic [DATA_W-1:0] pixelr5,
    input  logic [DATA_W-1:0] pixelr6,
    input  logic [DATA_W-1:0] pixelr7,
    input  logic [DATA_W-1:0] pixelr8,
    input  logic [DATA_W-1:0] pixelr9,
    output logic              out_valid,
    output logic [DATA_W-1:0] pixel_out,
    output logic [CNT_W-1:0]  pixel_cnt,
    output logic              done
);

    // Terminal count of one frame and the counter increment, sized to the counter.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_PIXELS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // Compare helpers. Unsigned compares only; on a tie either operand is
    // returned, which is the same value, so the result never depends on
    // tie order.
    // ------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] min2(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return (a < b) ? b : a;
    endfunction

    function automatic logic [DATA_W-1:0] min3(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        return min2(min2(a, b), c);
    endfunction

    function automatic logic [DATA_W-1:0] max3(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        return max2(max2(a, b), c);
    endfunction

    // Median of three: the larger of (smaller of a,b) and (smaller of the
    // larger of a,b and c).
    function automatic logic [DATA_W-1:0] med3(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    // ------------------------------------------------------------------
    // Acceptance: no backpressure, but once the frame is done every new
    // window is ignored until reset.
    // ------------------------------------------------------------------
    logic accept;
    assign accept = in_valid & ~done;

    // ------------------------------------------------------------------
    // Stage 1: sort each row into min / med / max.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r1_min_d, r1_med_d, r1_max_d;
    logic [DATA_W-1:0] r2_min_d, r2_med_d, r2_max_d;
    logic [DATA_W-1:0] r3_min_d, r3_med_d, r3_max_d;

    // Row sorting network for the incoming window.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // can leave it unassigned and infer a latch.
        r1_min_d = '0; r1_med_d = '0; r1_max_d = '0;
        r2_min_d = '0; r2_med_d = '0; r2_max_d = '0;
        r3_min_d = '0; r3_med_d = '0; r3_max_d = '0;

        r1_min_d = min3(pixelr1, pixelr2, pixelr3);
        r1_med_d = med3(pixelr1, pixelr2, pixelr3);
        r1_max_d = max3(pixelr1, pixelr2, pixelr3);

        r2_min_d = min3(pixelr4, pixelr5, pixelr6);
        r2_med_d = med3(pixelr4, pixelr5, pixelr6);
        r2_max_d = max3(pixelr4, pixelr5, pixelr6);

        r3_min_d = min3(pixelr7, pixelr8, pixelr9);
        r3_med_d = med3(pixelr7, pixelr8, pixelr9);
        r3_max_d = max3(pixelr7, pixelr8, pixelr9);
    end

    logic              s1_valid;
    logic              s1_bypass;
    logic [DATA_W-1:0] s1_centre;
    logic [DATA_W-1:0] s1_r1_min, s1_r1_med, s1_r1_max;
    logic [DATA_W-1:0] s1_r2_min, s1_r2_med, s1_r2_max;
    logic [DATA_W-1:0] s1_r3_min, s1_r3_med, s1_r3_max;

    // Stage 1 register: sorted rows, centre pixel, bypass flag and valid bit.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the edge.
        if (rst) begin
            // NOTE: data registers are reset too, not just the valid bits,
            // so no stale pixel from before the reset can reach the output.
            s1_valid  <= 1'b0;
            s1_bypass <= 1'b0;
            s1_centre <= '0;
            s1_r1_min <= '0; s1_r1_med <= '0; s1_r1_max <= '0;
            s1_r2_min <= '0; s1_r2_med <= '0; s1_r2_max <= '0;
            s1_r3_min <= '0; s1_r3_med <= '0; s1_r3_max <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_bypass <= bypass;
                s1_centre <= pixelr5;
                s1_r1_min <= r1_min_d; s1_r1_med <= r1_med_d; s1_r1_max <= r1_max_d;
                s1_r2_min <= r2_min_d; s1_r2_med <= r2_med_d; s1_r2_max <= r2_max_d;
                s1_r3_min <= r3_min_d; s1_r3_med <= r3_med_d; s1_r3_max <= r3_max_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: reduce the sorted rows to three candidates.
    //   a = max of row minima, b = median of row medians, c = min of row maxima
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] a_d, b_d, c_d;

    // Column reduction of the sorted rows.
    always_comb begin
        a_d = '0;
        b_d = '0;
        c_d = '0;
        a_d = max3(s1_r1_min, s1_r2_min, s1_r3_min);
        b_d = med3(s1_r1_med, s1_r2_med, s1_r3_med);
        c_d = min3(s1_r1_max, s1_r2_max, s1_r3_max);
    end

    logic              s2_valid;
    logic              s2_bypass;
    logic [DATA_W-1:0] s2_centre;
    logic [DATA_W-1:0] s2_a, s2_b, s2_c;

    // Stage 2 register: candidates plus the centre pixel and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_bypass <= 1'b0;
            s2_centre <= '0;
            s2_a      <= '0;
            s2_b      <= '0;
            s2_c      <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_bypass <= s1_bypass;
                s2_centre <= s1_centre;
                s2_a      <= a_d;
                s2_b      <= b_d;
                s2_c      <= c_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: final median or bypassed centre. Windows still in flight
    // when the frame completes drain silently: emit is held low by done.
    // ------------------------------------------------------------------
    logic              emit;
    logic [DATA_W-1:0] result_d;
    logic [CNT_W-1:0]  cnt_next;

    // Output selection, emit qualification and next count.
    always_comb begin
        result_d = '0;
        emit     = 1'b0;
        cnt_next = '0;
        result_d = s2_bypass ? s2_centre : med3(s2_a, s2_b, s2_c);
        emit     = s2_valid & ~done;
        cnt_next = pixel_cnt + CNT_ONE;
    end

    // Output register: pixel_out only changes when a pixel is emitted.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            pixel_out <= '0;
        end else begin
            out_valid <= emit;
            if (emit) begin
                pixel_out <= result_d;
            end
        end
    end

    // Frame counter: counts with each emitted pixel, saturates at the frame
    // size, and sets the sticky done on the edge the last pixel is emitted.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_cnt <= '0;
            done      <= 1'b0;
        end else if (emit && (pixel_cnt != CNT_MAX)) begin
            pixel_cnt <= cnt_next;
            if (cnt_next == CNT_MAX) begin
                done <= 1'b1;
            end
        end
    end

endmodule
